// File: rtl/wb_pmbus_alert_monitor.sv
// Multi-channel PMBus/SMBus ALERT# monitor on Wishbone: sync, debounce, sticky W1C, masked IRQ.
// Define PMBUS_ALERT_COUNT_EN to build the per-channel saturating event counters (CNT_SEL/COUNT).
module wb_pmbus_alert_monitor #(
    parameter int N_ALERTS    = 4,
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE_W  = 8,
    parameter int CNT_W       = 16
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    input  logic [31:0]         wb_adr_i,
    input  logic [31:0]         wb_dat_i,
    input  logic [3:0]          wb_sel_i,
    input  logic                wb_we_i,
    input  logic                wb_cyc_i,
    input  logic                wb_stb_i,
    output logic [31:0]         wb_dat_o,
    output logic                wb_ack_o,
    output logic                wb_err_o,
    input  logic [N_ALERTS-1:0] pmbus_alert_n,
    output logic                irq_o
);

    localparam logic [2:0] A_STATUS   = 3'd0;
    localparam logic [2:0] A_STICKY   = 3'd1;
    localparam logic [2:0] A_MASK     = 3'd2;
    localparam logic [2:0] A_DEBOUNCE = 3'd3;
    localparam logic [2:0] A_CNT_SEL  = 3'd4;
    localparam logic [2:0] A_COUNT    = 3'd5;

    logic [N_ALERTS-1:0]   r_sync [SYNC_STAGES];
    logic [N_ALERTS-1:0]   r_d;
    logic [DEBOUNCE_W-1:0] r_db_cnt [N_ALERTS];
    logic [N_ALERTS-1:0]   r_sticky;
    logic [N_ALERTS-1:0]   r_mask;
    logic [DEBOUNCE_W-1:0] r_debounce;
    logic                  r_ack;
    logic                  r_err;
    logic [31:0]           r_dat;
    logic                  r_irq;

    logic [N_ALERTS-1:0]   w_s;
    logic [DEBOUNCE_W:0]   w_thresh;
    logic [DEBOUNCE_W:0]   w_cnt_inc [N_ALERTS];
    logic [N_ALERTS-1:0]   w_flip;
    logic [N_ALERTS-1:0]   w_rise;
    logic                  w_req;
    logic [2:0]            w_adr;
    logic                  w_unmapped;
    logic                  w_wr;
    logic [N_ALERTS-1:0]   w_w1c;
    logic [31:0]           w_rdata;
    logic                  w_unused;

    assign w_unused = &{1'b0, wb_sel_i, wb_adr_i, wb_dat_i};

    // ---- synchroniser: chain samples the inverted (active-high) pin level
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            for (int k = 0; k < SYNC_STAGES; k++) r_sync[k] <= '0;
        end else begin
            r_sync[0] <= ~pmbus_alert_n;
            for (int k = 1; k < SYNC_STAGES; k++) r_sync[k] <= r_sync[k-1];
        end
    end

    assign w_s = r_sync[SYNC_STAGES-1];

    // ---- debounce: a zero threshold behaves as one
    assign w_thresh = (r_debounce == '0) ? {{DEBOUNCE_W{1'b0}}, 1'b1} : {1'b0, r_debounce};

    always_comb begin
        w_flip = '0;
        for (int i = 0; i < N_ALERTS; i++) begin
            w_cnt_inc[i] = {1'b0, r_db_cnt[i]} + {{DEBOUNCE_W{1'b0}}, 1'b1};
            w_flip[i]    = (w_s[i] != r_d[i]) && (w_cnt_inc[i] >= w_thresh);
        end
    end

    // A flip towards s=1 is by definition a 0->1 edge of d.
    assign w_rise = w_flip & w_s;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_d <= '0;
            for (int i = 0; i < N_ALERTS; i++) r_db_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < N_ALERTS; i++) begin
                if (w_s[i] == r_d[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (w_flip[i]) begin
                    r_d[i]      <= w_s[i];
                    r_db_cnt[i] <= '0;
                end else begin
                    r_db_cnt[i] <= w_cnt_inc[i][DEBOUNCE_W-1:0];
                end
            end
        end
    end

    // ---- bus decode: ack/err mask the following cycle so each request answers once
    assign w_req      = wb_stb_i & wb_cyc_i & ~r_ack & ~r_err;
    assign w_adr      = wb_adr_i[4:2];
    assign w_unmapped = w_adr[2] & w_adr[1];
    assign w_wr       = w_req & wb_we_i & ~w_unmapped;
    assign w_w1c      = (w_wr && w_adr == A_STICKY) ? wb_dat_i[N_ALERTS-1:0] : '0;

`ifdef PMBUS_ALERT_COUNT_EN
    logic [4:0]          r_cnt_sel;
    logic [CNT_W-1:0]    r_count [N_ALERTS];
    logic [CNT_W-1:0]    w_cnt_rd;
    logic [N_ALERTS-1:0] w_cnt_clr;

    // Out-of-range selections match no channel: reads give 0, clears hit nothing.
    always_comb begin
        w_cnt_rd  = '0;
        w_cnt_clr = '0;
        for (int i = 0; i < N_ALERTS; i++) begin
            if (r_cnt_sel == 5'(i)) begin
                w_cnt_rd     = r_count[i];
                w_cnt_clr[i] = w_wr && (w_adr == A_COUNT);
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_cnt_sel <= '0;
            for (int i = 0; i < N_ALERTS; i++) r_count[i] <= '0;
        end else begin
            if (w_wr && w_adr == A_CNT_SEL) r_cnt_sel <= wb_dat_i[4:0];
            for (int i = 0; i < N_ALERTS; i++) begin
                if (w_rise[i]) begin
                    if (w_cnt_clr[i])
                        r_count[i] <= {{(CNT_W-1){1'b0}}, 1'b1};
                    else if (!(&r_count[i]))
                        r_count[i] <= r_count[i] + {{(CNT_W-1){1'b0}}, 1'b1};
                end else if (w_cnt_clr[i]) begin
                    r_count[i] <= '0;
                end
            end
        end
    end
`endif

    always_comb begin
        w_rdata = '0;
        case (w_adr)
            A_STATUS:   w_rdata = 32'(r_d);
            A_STICKY:   w_rdata = 32'(r_sticky);
            A_MASK:     w_rdata = 32'(r_mask);
            A_DEBOUNCE: w_rdata = 32'(r_debounce);
`ifdef PMBUS_ALERT_COUNT_EN
            A_CNT_SEL:  w_rdata = 32'(r_cnt_sel);
            A_COUNT:    w_rdata = 32'(w_cnt_rd);
`endif
            default:    w_rdata = '0;
        endcase
    end

    // ---- register file, bus response and interrupt
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_sticky   <= '0;
            r_mask     <= '0;
            r_debounce <= DEBOUNCE_W'(4);
            r_ack      <= 1'b0;
            r_err      <= 1'b0;
            r_dat      <= '0;
            r_irq      <= 1'b0;
        end else begin
            r_sticky <= (r_sticky & ~w_w1c) | w_rise;
            if (w_wr && w_adr == A_MASK)     r_mask     <= wb_dat_i[N_ALERTS-1:0];
            if (w_wr && w_adr == A_DEBOUNCE) r_debounce <= wb_dat_i[DEBOUNCE_W-1:0];
            r_ack <= w_req & ~w_unmapped;
            r_err <= w_req & w_unmapped;
            r_dat <= (w_req && !wb_we_i && !w_unmapped) ? w_rdata : '0;
            r_irq <= |(r_sticky & r_mask);
        end
    end

    assign wb_ack_o = r_ack;
    assign wb_err_o = r_err;
    assign wb_dat_o = r_dat;
    assign irq_o    = r_irq;

endmodule
